// File: rtl/alu_issue_queue_param.sv
// alu_issue_queue_param: DEPTH-entry age-ordered ALU reservation station.
// Entries wake up by snooping the CDB. The oldest entry with both operands valid issues
// through a valid/ready handshake, and the younger entries compact down behind it.
module alu_issue_queue_param #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned OPC_W  = 6,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [DATA_W-1:0] disp_op1_data,
  input  logic [TAG_W-1:0]  disp_op1_tag,
  input  logic              disp_op1_valid,
  input  logic [DATA_W-1:0] disp_op2_data,
  input  logic [TAG_W-1:0]  disp_op2_tag,
  input  logic              disp_op2_valid,
  input  logic [TAG_W-1:0]  disp_rd_tag,
  input  logic [OPC_W-1:0]  disp_opc,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [DATA_W-1:0] iss_op1,
  output logic [DATA_W-1:0] iss_op2,
  output logic [TAG_W-1:0]  iss_rd_tag,
  output logic [OPC_W-1:0]  iss_opc,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  // Registered entries; index 0 is the oldest, occupied entries are 0..r_count-1.
  logic              r_busy     [DEPTH];
  logic [DATA_W-1:0] r_op1_data [DEPTH];
  logic [TAG_W-1:0]  r_op1_tag  [DEPTH];
  logic              r_op1_vld  [DEPTH];
  logic [DATA_W-1:0] r_op2_data [DEPTH];
  logic [TAG_W-1:0]  r_op2_tag  [DEPTH];
  logic              r_op2_vld  [DEPTH];
  logic [TAG_W-1:0]  r_rd_tag   [DEPTH];
  logic [OPC_W-1:0]  r_opc      [DEPTH];
  logic [CNT_W-1:0]  r_count;

  // Stored entries after CDB wakeup; slot DEPTH is an always-empty filler for the shift.
  logic              w_src_busy     [DEPTH+1];
  logic [DATA_W-1:0] w_src_op1_data [DEPTH+1];
  logic [TAG_W-1:0]  w_src_op1_tag  [DEPTH+1];
  logic              w_src_op1_vld  [DEPTH+1];
  logic [DATA_W-1:0] w_src_op2_data [DEPTH+1];
  logic [TAG_W-1:0]  w_src_op2_tag  [DEPTH+1];
  logic              w_src_op2_vld  [DEPTH+1];
  logic [TAG_W-1:0]  w_src_rd_tag   [DEPTH+1];
  logic [OPC_W-1:0]  w_src_opc      [DEPTH+1];

  // Next-state entries.
  logic              w_busy_d     [DEPTH];
  logic [DATA_W-1:0] w_op1_data_d [DEPTH];
  logic [TAG_W-1:0]  w_op1_tag_d  [DEPTH];
  logic              w_op1_vld_d  [DEPTH];
  logic [DATA_W-1:0] w_op2_data_d [DEPTH];
  logic [TAG_W-1:0]  w_op2_tag_d  [DEPTH];
  logic              w_op2_vld_d  [DEPTH];
  logic [TAG_W-1:0]  w_rd_tag_d   [DEPTH];
  logic [OPC_W-1:0]  w_opc_d      [DEPTH];
  logic [CNT_W-1:0]  w_count_d;

  logic              w_sel_found;
  logic [IDX_W-1:0]  w_sel_idx;
  logic              w_iss_fire;
  logic              w_disp_fire;
  logic [CNT_W-1:0]  w_wr_idx;
  logic [DATA_W-1:0] w_new_op1_data;
  logic              w_new_op1_vld;
  logic [DATA_W-1:0] w_new_op2_data;
  logic              w_new_op2_vld;

  assign disp_ready  = (r_count != CNT_W'(DEPTH));
  assign count       = r_count;
  assign w_iss_fire  = w_sel_found & iss_ready;
  assign w_disp_fire = disp_valid & disp_ready;
  // An issue frees a slot below the tail, so the new entry lands one lower.
  assign w_wr_idx    = r_count - CNT_W'(w_iss_fire);
  assign w_count_d   = r_count + CNT_W'(w_disp_fire) - CNT_W'(w_iss_fire);

  // Age-priority select: lowest busy index with both operands valid.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!w_sel_found && r_busy[i] && r_op1_vld[i] && r_op2_vld[i]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(i);
      end
    end
  end

  // Issue outputs show the selected entry, zero when nothing is selected.
  always_comb begin
    iss_valid  = w_sel_found;
    iss_op1    = '0;
    iss_op2    = '0;
    iss_rd_tag = '0;
    iss_opc    = '0;
    if (w_sel_found) begin
      iss_op1    = r_op1_data[w_sel_idx];
      iss_op2    = r_op2_data[w_sel_idx];
      iss_rd_tag = r_rd_tag[w_sel_idx];
      iss_opc    = r_opc[w_sel_idx];
    end
  end

  // CDB wakeup of stored entries; an already-valid operand ignores the broadcast.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_src_busy[i]     = r_busy[i];
      w_src_op1_data[i] = r_op1_data[i];
      w_src_op1_tag[i]  = r_op1_tag[i];
      w_src_op1_vld[i]  = r_op1_vld[i];
      w_src_op2_data[i] = r_op2_data[i];
      w_src_op2_tag[i]  = r_op2_tag[i];
      w_src_op2_vld[i]  = r_op2_vld[i];
      w_src_rd_tag[i]   = r_rd_tag[i];
      w_src_opc[i]      = r_opc[i];
      if (r_busy[i] && !r_op1_vld[i] && cdb_valid && (r_op1_tag[i] == cdb_tag)) begin
        w_src_op1_data[i] = cdb_data;
        w_src_op1_vld[i]  = 1'b1;
      end
      if (r_busy[i] && !r_op2_vld[i] && cdb_valid && (r_op2_tag[i] == cdb_tag)) begin
        w_src_op2_data[i] = cdb_data;
        w_src_op2_vld[i]  = 1'b1;
      end
    end
    w_src_busy[DEPTH]     = 1'b0;
    w_src_op1_data[DEPTH] = '0;
    w_src_op1_tag[DEPTH]  = '0;
    w_src_op1_vld[DEPTH]  = 1'b0;
    w_src_op2_data[DEPTH] = '0;
    w_src_op2_tag[DEPTH]  = '0;
    w_src_op2_vld[DEPTH]  = 1'b0;
    w_src_rd_tag[DEPTH]   = '0;
    w_src_opc[DEPTH]      = '0;
  end

  // Dispatched operands snoop the same-cycle CDB.
  always_comb begin
    w_new_op1_data = disp_op1_data;
    w_new_op1_vld  = disp_op1_valid;
    w_new_op2_data = disp_op2_data;
    w_new_op2_vld  = disp_op2_valid;
    if (!disp_op1_valid && cdb_valid && (disp_op1_tag == cdb_tag)) begin
      w_new_op1_data = cdb_data;
      w_new_op1_vld  = 1'b1;
    end
    if (!disp_op2_valid && cdb_valid && (disp_op2_tag == cdb_tag)) begin
      w_new_op2_data = cdb_data;
      w_new_op2_vld  = 1'b1;
    end
  end

  // Next state: entries above an issued slot shift down by one, then dispatch writes the tail.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (w_iss_fire && (IDX_W'(i) >= w_sel_idx)) begin
        w_busy_d[i]     = w_src_busy[i+1];
        w_op1_data_d[i] = w_src_op1_data[i+1];
        w_op1_tag_d[i]  = w_src_op1_tag[i+1];
        w_op1_vld_d[i]  = w_src_op1_vld[i+1];
        w_op2_data_d[i] = w_src_op2_data[i+1];
        w_op2_tag_d[i]  = w_src_op2_tag[i+1];
        w_op2_vld_d[i]  = w_src_op2_vld[i+1];
        w_rd_tag_d[i]   = w_src_rd_tag[i+1];
        w_opc_d[i]      = w_src_opc[i+1];
      end else begin
        w_busy_d[i]     = w_src_busy[i];
        w_op1_data_d[i] = w_src_op1_data[i];
        w_op1_tag_d[i]  = w_src_op1_tag[i];
        w_op1_vld_d[i]  = w_src_op1_vld[i];
        w_op2_data_d[i] = w_src_op2_data[i];
        w_op2_tag_d[i]  = w_src_op2_tag[i];
        w_op2_vld_d[i]  = w_src_op2_vld[i];
        w_rd_tag_d[i]   = w_src_rd_tag[i];
        w_opc_d[i]      = w_src_opc[i];
      end
      if (w_disp_fire && (CNT_W'(i) == w_wr_idx)) begin
        w_busy_d[i]     = 1'b1;
        w_op1_data_d[i] = w_new_op1_data;
        w_op1_tag_d[i]  = disp_op1_tag;
        w_op1_vld_d[i]  = w_new_op1_vld;
        w_op2_data_d[i] = w_new_op2_data;
        w_op2_tag_d[i]  = disp_op2_tag;
        w_op2_vld_d[i]  = w_new_op2_vld;
        w_rd_tag_d[i]   = disp_rd_tag;
        w_opc_d[i]      = disp_opc;
      end
    end
  end

  // Occupancy state; rst and flush drop every entry and that cycle's dispatch/issue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_busy[i] <= 1'b0;
      end
      r_count <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_busy[i] <= w_busy_d[i];
      end
      r_count <= w_count_d;
    end
  end

  // Entry payload; only meaningful while the matching busy bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      r_op1_data[i] <= w_op1_data_d[i];
      r_op1_tag[i]  <= w_op1_tag_d[i];
      r_op1_vld[i]  <= w_op1_vld_d[i];
      r_op2_data[i] <= w_op2_data_d[i];
      r_op2_tag[i]  <= w_op2_tag_d[i];
      r_op2_vld[i]  <= w_op2_vld_d[i];
      r_rd_tag[i]   <= w_rd_tag_d[i];
      r_opc[i]      <= w_opc_d[i];
    end
  end

endmodule

// File: tb/tb_alu_issue_queue_param.sv
// Testbench for alu_issue_queue_param: directed vector table, hand sequences for the
// multi-cycle corners, and random traffic against a queue-based reference model.
module tb_alu_issue_queue_param;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned OPC_W  = 6;
  localparam int unsigned CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst, flush, disp_valid, disp_ready;
  logic [DATA_W-1:0] disp_op1_data, disp_op2_data, cdb_data;
  logic [TAG_W-1:0]  disp_op1_tag, disp_op2_tag, disp_rd_tag, cdb_tag;
  logic              disp_op1_valid, disp_op2_valid, cdb_valid;
  logic [OPC_W-1:0]  disp_opc;
  logic              iss_valid, iss_ready;
  logic [DATA_W-1:0] iss_op1, iss_op2;
  logic [TAG_W-1:0]  iss_rd_tag;
  logic [OPC_W-1:0]  iss_opc;
  logic [CNT_W-1:0]  count;

  always #5 clk = ~clk;

  alu_issue_queue_param #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .TAG_W (TAG_W),
    .OPC_W (OPC_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .disp_valid    (disp_valid),
    .disp_ready    (disp_ready),
    .disp_op1_data (disp_op1_data),
    .disp_op1_tag  (disp_op1_tag),
    .disp_op1_valid(disp_op1_valid),
    .disp_op2_data (disp_op2_data),
    .disp_op2_tag  (disp_op2_tag),
    .disp_op2_valid(disp_op2_valid),
    .disp_rd_tag   (disp_rd_tag),
    .disp_opc      (disp_opc),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_data      (cdb_data),
    .iss_valid     (iss_valid),
    .iss_ready     (iss_ready),
    .iss_op1       (iss_op1),
    .iss_op2       (iss_op2),
    .iss_rd_tag    (iss_rd_tag),
    .iss_opc       (iss_opc),
    .count         (count)
  );

  typedef struct {
    logic        rst, flush, dv;
    logic [31:0] d1, d2, cd;
    logic [5:0]  t1, t2, rd, opc, ct;
    logic        v1, v2, cv, ir;
  } stim_t;

  typedef struct {
    logic [31:0] d1, d2;
    logic [5:0]  t1, t2, rd, opc;
    logic        v1, v2;
  } ent_t;

  typedef struct {
    stim_t       s;
    logic        iv;
    logic [31:0] op1, op2;
    logic [5:0]  rd;
    logic [2:0]  cnt;
    logic        dr;
  } vec_t;

  int   n_checks = 0;
  int   n_errs   = 0;
  ent_t mq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle(input logic ir);
    stim_t s;
    s.rst = 1'b0; s.flush = 1'b0; s.dv = 1'b0;
    s.d1 = '0; s.d2 = '0; s.cd = '0;
    s.t1 = '0; s.t2 = '0; s.rd = '0; s.opc = '0; s.ct = '0;
    s.v1 = 1'b0; s.v2 = 1'b0; s.cv = 1'b0; s.ir = ir;
    return s;
  endfunction

  function automatic stim_t disp(input logic [31:0] d1, input logic [5:0] t1, input logic v1,
                                 input logic [31:0] d2, input logic [5:0] t2, input logic v2,
                                 input logic [5:0] rd, input logic ir);
    stim_t s = idle(ir);
    s.dv = 1'b1;
    s.d1 = d1; s.t1 = t1; s.v1 = v1;
    s.d2 = d2; s.t2 = t2; s.v2 = v2;
    s.rd = rd;
    return s;
  endfunction

  function automatic stim_t cdb(input logic [5:0] tag, input logic [31:0] data, input logic ir);
    stim_t s = idle(ir);
    s.cv = 1'b1; s.ct = tag; s.cd = data;
    return s;
  endfunction

  function automatic vec_t mkv(input stim_t s, input logic iv, input logic [31:0] o1,
                               input logic [31:0] o2, input logic [5:0] rd, input int cnt,
                               input logic dr);
    vec_t v;
    v.s = s; v.iv = iv; v.op1 = o1; v.op2 = o2; v.rd = rd; v.cnt = 3'(cnt); v.dr = dr;
    return v;
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rst; flush = s.flush; disp_valid = s.dv;
    disp_op1_data = s.d1; disp_op1_tag = s.t1; disp_op1_valid = s.v1;
    disp_op2_data = s.d2; disp_op2_tag = s.t2; disp_op2_valid = s.v2;
    disp_rd_tag = s.rd; disp_opc = s.opc;
    cdb_valid = s.cv; cdb_tag = s.ct; cdb_data = s.cd;
    iss_ready = s.ir;
  endtask

  function automatic int model_sel();
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].v1 && mq[i].v2) return i;
    end
    return -1;
  endfunction

  // Reference: an ordered list; issue deletes the oldest ready element, dispatch appends.
  task automatic model_step(input stim_t s);
    int   sel;
    logic ifire, dfire;
    ent_t e;
    if (s.rst || s.flush) begin
      mq.delete();
      return;
    end
    sel   = model_sel();
    ifire = (sel >= 0) && s.ir;
    dfire = s.dv && (mq.size() < DEPTH);
    foreach (mq[i]) begin
      if (s.cv && !mq[i].v1 && mq[i].t1 == s.ct) begin mq[i].d1 = s.cd; mq[i].v1 = 1'b1; end
      if (s.cv && !mq[i].v2 && mq[i].t2 == s.ct) begin mq[i].d2 = s.cd; mq[i].v2 = 1'b1; end
    end
    if (ifire) mq.delete(sel);
    if (dfire) begin
      e.d1 = s.d1; e.t1 = s.t1; e.v1 = s.v1;
      e.d2 = s.d2; e.t2 = s.t2; e.v2 = s.v2;
      e.rd = s.rd; e.opc = s.opc;
      if (s.cv && !e.v1 && e.t1 == s.ct) begin e.d1 = s.cd; e.v1 = 1'b1; end
      if (s.cv && !e.v2 && e.t2 == s.ct) begin e.d2 = s.cd; e.v2 = 1'b1; end
      mq.push_back(e);
    end
  endtask

  task automatic model_check();
    int   sel = model_sel();
    ent_t e;
    e.d1 = '0; e.d2 = '0; e.t1 = '0; e.t2 = '0; e.rd = '0; e.opc = '0; e.v1 = 0; e.v2 = 0;
    if (sel >= 0) e = mq[sel];
    chk("model_iss_valid", 64'(iss_valid), 64'(sel >= 0));
    chk("model_iss_op1", 64'(iss_op1), 64'(e.d1));
    chk("model_iss_op2", 64'(iss_op2), 64'(e.d2));
    chk("model_iss_rd_tag", 64'(iss_rd_tag), 64'(e.rd));
    chk("model_iss_opc", 64'(iss_opc), 64'(e.opc));
    chk("model_count", 64'(count), 64'(mq.size()));
    chk("model_disp_ready", 64'(disp_ready), 64'(mq.size() < DEPTH));
  endtask

  // One clock: drive at negedge, advance model at posedge, check at the next negedge.
  task automatic tick(input stim_t s);
    apply(s);
    @(posedge clk);
    model_step(s);
    @(negedge clk);
    model_check();
  endtask

  vec_t  tbl[10];
  stim_t s;

  initial begin
    s = idle(1'b1);
    s.rst = 1'b1;
    apply(s);

    tbl[0] = mkv(s, 0, 0, 0, 0, 0, 1);
    tbl[1] = mkv(disp(5, 0, 1, 7, 0, 1, 3, 1), 1, 5, 7, 3, 1, 1);
    tbl[2] = mkv(idle(1), 0, 0, 0, 0, 0, 1);
    tbl[3] = mkv(disp(0, 9, 0, 1, 0, 1, 10, 1), 0, 0, 0, 0, 1, 1);
    tbl[4] = mkv(disp(2, 0, 1, 3, 0, 1, 11, 1), 1, 2, 3, 11, 2, 1);
    tbl[5] = mkv(idle(1), 0, 0, 0, 0, 1, 1);
    tbl[6] = mkv(cdb(9, 32'hDEAD, 1), 1, 32'hDEAD, 1, 10, 1, 1);
    tbl[7] = mkv(idle(1), 0, 0, 0, 0, 0, 1);
    s = disp(4, 0, 1, 0, 12, 0, 13, 1);
    s.cv = 1'b1; s.ct = 12; s.cd = 32'h55;
    tbl[8] = mkv(s, 1, 4, 32'h55, 13, 1, 1);
    tbl[9] = mkv(idle(1), 0, 0, 0, 0, 0, 1);

    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].s);
      chk($sformatf("vec%0d_iss_valid", i), 64'(iss_valid), 64'(tbl[i].iv));
      chk($sformatf("vec%0d_iss_op1", i), 64'(iss_op1), 64'(tbl[i].op1));
      chk($sformatf("vec%0d_iss_op2", i), 64'(iss_op2), 64'(tbl[i].op2));
      chk($sformatf("vec%0d_iss_rd_tag", i), 64'(iss_rd_tag), 64'(tbl[i].rd));
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].cnt));
      chk($sformatf("vec%0d_disp_ready", i), 64'(disp_ready), 64'(tbl[i].dr));
    end

    // Fill with nothing ready, then wake entry 2; entry 3 must compact into slot 2.
    for (int k = 0; k < 4; k++) tick(disp(k, 6'(20 + k), 0, 100, 0, 1, 6'(30 + k), 1));
    chk("full_count", 64'(count), 4);
    chk("full_disp_ready", 64'(disp_ready), 0);
    tick(cdb(22, 32'h77, 1));
    chk("wake2_iss_valid", 64'(iss_valid), 1);
    chk("wake2_rd_tag", 64'(iss_rd_tag), 32);
    tick(idle(1));
    chk("after_issue_count", 64'(count), 3);
    chk("after_issue_disp_ready", 64'(disp_ready), 1);
    tick(cdb(23, 32'h88, 1));
    chk("shifted_rd_tag", 64'(iss_rd_tag), 33);
    s = idle(1); s.flush = 1'b1;
    tick(s);

    // Issue of entry 1 with a simultaneous dispatch; order checked by one shared wakeup.
    tick(disp(0, 50, 0, 1, 0, 1, 1, 0));
    tick(disp(9, 0, 1, 8, 0, 1, 2, 0));
    tick(disp(0, 50, 0, 1, 0, 1, 3, 0));
    chk("mid_sel_rd_tag", 64'(iss_rd_tag), 2);
    tick(disp(0, 50, 0, 1, 0, 1, 4, 1));
    chk("issue_disp_count", 64'(count), 3);
    chk("issue_disp_iss_valid", 64'(iss_valid), 0);
    tick(cdb(50, 32'hAB, 1));
    chk("order0_rd_tag", 64'(iss_rd_tag), 1);
    tick(idle(1));
    chk("order1_rd_tag", 64'(iss_rd_tag), 3);
    tick(idle(1));
    chk("order2_rd_tag", 64'(iss_rd_tag), 4);
    tick(idle(1));
    chk("order_drained_count", 64'(count), 0);

    // Flush, then reset, each with a competing dispatch.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) tick(disp(0, 60, 0, 1, 0, 1, 6'(k + 5), 1));
      chk($sformatf("clr%0d_pre_count", r), 64'(count), 3);
      s = disp(1, 0, 1, 2, 0, 1, 9, 1);
      if (r == 0) s.flush = 1'b1;
      else s.rst = 1'b1;
      tick(s);
      chk($sformatf("clr%0d_count", r), 64'(count), 0);
      chk($sformatf("clr%0d_iss_valid", r), 64'(iss_valid), 0);
      tick(cdb(60, 32'h1, 1));
      chk($sformatf("clr%0d_nothing_captured", r), 64'(iss_valid), 0);
    end

    // Random traffic with a small tag space to provoke matches and backpressure.
    for (int n = 0; n < 600; n++) begin
      s = idle($urandom_range(0, 3) != 0);
      s.rst   = ($urandom_range(0, 149) == 0);
      s.flush = ($urandom_range(0, 59) == 0);
      s.dv    = ($urandom_range(0, 2) != 0);
      s.d1 = $urandom; s.t1 = 6'($urandom_range(0, 7)); s.v1 = $urandom_range(0, 1) != 0;
      s.d2 = $urandom; s.t2 = 6'($urandom_range(0, 7)); s.v2 = $urandom_range(0, 1) != 0;
      s.rd = 6'($urandom_range(0, 63)); s.opc = 6'($urandom_range(0, 63));
      s.cv = ($urandom_range(0, 1) != 0); s.ct = 6'($urandom_range(0, 7)); s.cd = $urandom;
      tick(s);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
